// File: rtl/apple_bus_seq_if.sv
// Slot-side bus signals of the GR8RAM timing front-end.
// The slave modport faces the sequencer; the master modport faces whatever drives the slot.
interface apple_bus_seq_if;
  logic       PHI1;
  logic       nDEVSEL;
  logic       nIOSEL;
  logic       nIOSTRB;
  logic [2:0] S;
  logic       PHI0seen;
  logic       Synced;
  logic       RefReq;
  logic       CSDBEN;
  logic       DEVSELq;
  logic       IOSELq;
  logic       IOSTRBq;
  logic       SlotAct;

  modport slave (
    input  PHI1, nDEVSEL, nIOSEL, nIOSTRB,
    output S, PHI0seen, Synced, RefReq, CSDBEN, DEVSELq, IOSELq, IOSTRBq, SlotAct
  );

  modport master (
    output PHI1, nDEVSEL, nIOSEL, nIOSTRB,
    input  S, PHI0seen, Synced, RefReq, CSDBEN, DEVSELq, IOSELq, IOSTRBq, SlotAct
  );
endinterface

// File: rtl/apple_bus_seq.sv
// Apple II bus-cycle sequencer: filters PHI1, locks the state counter S to it, and derives
// the refresh request, data-bus enable window and latched slot selects.
module apple_bus_seq #(
  parameter int unsigned PHI1_FILT    = 2,
  parameter int unsigned REF_PERIOD   = 13,
  parameter int unsigned SYNC_TIMEOUT = 16
) (
  input  logic           C7M,
  input  logic           RES,
  apple_bus_seq_if.slave bus
);

  localparam int unsigned REF_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam int unsigned WD_W  = $clog2(SYNC_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_1    = 3'd1,
    ST_2    = 3'd2,
    ST_3    = 3'd3,
    ST_4    = 3'd4,
    ST_5    = 3'd5,
    ST_6    = 3'd6,
    ST_7    = 3'd7
  } bus_state_e;

  bus_state_e           state_q, state_d;
  logic [PHI1_FILT-1:0] filt_q, filt_d;
  logic                 phi1f_q, phi1f_d;
  logic                 phi1d_q;
  logic                 phi0seen_q, phi0seen_d;
  logic                 synced_q, synced_d;
  logic [REF_W-1:0]     ref_q, ref_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic                 csdben_q, csdben_d;
  logic                 devsel_q, devsel_d;
  logic                 iosel_q, iosel_d;
  logic                 iostrb_q, iostrb_d;
  logic                 rise;
  logic                 expire;
  logic                 load1;

  // State register
  always_ff @(posedge C7M) begin
    if (RES) begin
      state_q    <= ST_IDLE;
      filt_q     <= '0;
      phi1f_q    <= 1'b0;
      phi1d_q    <= 1'b0;
      phi0seen_q <= 1'b0;
      synced_q   <= 1'b0;
      ref_q      <= '0;
      wd_q       <= '0;
      csdben_q   <= 1'b0;
      devsel_q   <= 1'b0;
      iosel_q    <= 1'b0;
      iostrb_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      filt_q     <= filt_d;
      phi1f_q    <= phi1f_d;
      phi1d_q    <= phi1f_q;
      phi0seen_q <= phi0seen_d;
      synced_q   <= synced_d;
      ref_q      <= ref_d;
      wd_q       <= wd_d;
      csdben_q   <= csdben_d;
      devsel_q   <= devsel_d;
      iosel_q    <= iosel_d;
      iostrb_q   <= iostrb_d;
    end
  end

  // Next-state logic; expiry is the edge on which the watchdog reaches the timeout
  always_comb begin
    state_d    = state_q;
    filt_d     = filt_q;
    phi1f_d    = phi1f_q;
    phi0seen_d = phi0seen_q;
    synced_d   = synced_q;
    ref_d      = ref_q;
    wd_d       = wd_q;
    csdben_d   = 1'b0;
    devsel_d   = devsel_q;
    iosel_d    = iosel_q;
    iostrb_d   = iostrb_q;

    rise   = phi1f_q & ~phi1d_q;
    expire = synced_q & ~rise & (wd_q == WD_W'(SYNC_TIMEOUT - 1));
    load1  = rise & phi0seen_q;

    filt_d[0] = bus.PHI1;
    for (int i = 1; i < int'(PHI1_FILT); i++) begin
      filt_d[i] = filt_q[i-1];
    end
    if (&filt_q) begin
      phi1f_d = 1'b1;
    end else if (~|filt_q) begin
      phi1f_d = 1'b0;
    end

    if (expire) begin
      state_d = ST_IDLE;
    end else if (load1) begin
      state_d = ST_1;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_7) begin
      state_d = ST_7;
    end else begin
      state_d = bus_state_e'(state_q + 3'd1);
    end

    if (expire) begin
      phi0seen_d = 1'b0;
      synced_d   = 1'b0;
    end else begin
      if (!phi1f_q) phi0seen_d = 1'b1;
      if (load1)    synced_d   = 1'b1;
    end

    if (rise) begin
      wd_d = '0;
    end else if (synced_q && (wd_q < WD_W'(SYNC_TIMEOUT))) begin
      wd_d = wd_q + WD_W'(1);
    end

    if ((state_q == ST_3) && (state_d == ST_4)) begin
      ref_d = (ref_q == REF_W'(REF_PERIOD - 1)) ? '0 : ref_q + REF_W'(1);
    end

    csdben_d = (state_q >= ST_4) && (state_d != ST_IDLE);

    // Selects clear whenever a new cycle starts or lock is absent
    if ((state_d == ST_IDLE) || (state_d == ST_1)) begin
      devsel_d = 1'b0;
      iosel_d  = 1'b0;
      iostrb_d = 1'b0;
    end else begin
      if ((state_q == ST_4) || (state_q == ST_5)) begin
        devsel_d = devsel_q | ~bus.nDEVSEL;
        iosel_d  = iosel_q  | ~bus.nIOSEL;
      end
      if ((state_q >= ST_3) && (state_q <= ST_5)) begin
        iostrb_d = iostrb_q | ~bus.nIOSTRB;
      end
    end
  end

  assign bus.S        = state_q;
  assign bus.PHI0seen = phi0seen_q;
  assign bus.Synced   = synced_q;
  assign bus.RefReq   = (state_q == ST_1) && (ref_q == '0);
  assign bus.CSDBEN   = csdben_q;
  assign bus.DEVSELq  = devsel_q;
  assign bus.IOSELq   = iosel_q;
  assign bus.IOSTRBq  = iostrb_q;
  assign bus.SlotAct  = devsel_q | iosel_q | iostrb_q;

endmodule
